// File: rtl/onbellek_denetleyici.sv
// onbellek_denetleyici: direct-mapped, write-back, write-allocate data cache
// controller. Line data sits in an external single-port BRAM with a one-cycle
// registered read; tags and valid/dirty bits are kept here in registers.
// Optional hit/miss counters are enabled by defining ONBELLEK_ISTATISTIK_EN.
module onbellek_denetleyici #(
    parameter int INDEKS_BIT = 7
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           islemci_istek_adres_i,
    input  logic [31:0]           islemci_istek_veri_i,
    input  logic                  islemci_istek_gecerli_i,
    input  logic                  islemci_istek_yaz_i,
    output logic                  islemci_istek_hazir_o,
    output logic [31:0]           islemci_cevap_veri_o,
    output logic                  islemci_cevap_gecerli_o,
    input  logic                  islemci_cevap_hazir_i,
    output logic [31:0]           anabellek_istek_adres_o,
    output logic [127:0]          anabellek_istek_veri_o,
    output logic                  anabellek_istek_gecerli_o,
    output logic                  anabellek_istek_yaz_gecerli_o,
    input  logic                  anabellek_istek_hazir_i,
    input  logic [127:0]          anabellek_cevap_veri_i,
    input  logic                  anabellek_cevap_gecerli_i,
    output logic                  anabellek_cevap_hazir_o,
    output logic                  onbellek_istek_gecerli_o,
    output logic                  onbellek_istek_yaz_o,
    output logic [127:0]          onbellek_istek_veri_o,
    output logic [INDEKS_BIT-1:0] onbellek_istek_adres_o,
    input  logic [127:0]          onbellek_cevap_veri_i
`ifdef ONBELLEK_ISTATISTIK_EN
    ,
    output logic [31:0]           isabet_sayisi_o,
    output logic [31:0]           iska_sayisi_o
`endif
);

    localparam int SATIR      = 1 << INDEKS_BIT;
    localparam int ETIKET_BIT = 32 - 4 - INDEKS_BIT;

    typedef enum logic [2:0] {
        BOSTA,
        KONTROL,
        GERIYAZ,
        GETIR,
        BEKLE,
        CEVAP
    } durum_t;

    durum_t              durum_q, durum_d;
    logic [31:2]         adres_q, adres_d;
    logic [31:0]         veri_q, veri_d;
    logic                yaz_q, yaz_d;
    logic [127:0]        kurban_q, kurban_d;
    logic [31:0]         cevap_veri_q, cevap_veri_d;
    logic [SATIR-1:0]    gecerli_q, gecerli_d;
    logic [SATIR-1:0]    kirli_q, kirli_d;
    logic [ETIKET_BIT-1:0] etiket_q [SATIR];
    logic                etiket_yaz;

    logic [INDEKS_BIT-1:0] indeks;
    logic [ETIKET_BIT-1:0] etiket;
    logic [1:0]            kelime;
    logic                  isabet;
    logic [127:0]          bram_birlesik;
    logic [127:0]          getirilen_satir;

    // Byte-offset bits carry no information for word accesses.
    logic unused_adres_bitleri;
    assign unused_adres_bitleri = ^islemci_istek_adres_i[1:0];

    function automatic logic [31:0] kelime_sec(input logic [127:0] satir,
                                               input logic [1:0]   w);
        return satir[{w, 5'b00000} +: 32];
    endfunction

    function automatic logic [127:0] kelime_yaz(input logic [127:0] satir,
                                                input logic [1:0]   w,
                                                input logic [31:0]  k);
        logic [127:0] s;
        s = satir;
        s[{w, 5'b00000} +: 32] = k;
        return s;
    endfunction

    assign indeks          = adres_q[4 +: INDEKS_BIT];
    assign etiket          = adres_q[31 -: ETIKET_BIT];
    assign kelime          = adres_q[3:2];
    assign isabet          = gecerli_q[indeks] & (etiket_q[indeks] == etiket);
    assign bram_birlesik   = kelime_yaz(onbellek_cevap_veri_i, kelime, veri_q);
    assign getirilen_satir = yaz_q ? kelime_yaz(anabellek_cevap_veri_i, kelime, veri_q)
                                   : anabellek_cevap_veri_i;
    assign islemci_cevap_veri_o = cevap_veri_q;

    // Next-state, register updates and all port outputs, decoded from the state.
    always_comb begin
        durum_d      = durum_q;
        adres_d      = adres_q;
        veri_d       = veri_q;
        yaz_d        = yaz_q;
        kurban_d     = kurban_q;
        cevap_veri_d = cevap_veri_q;
        gecerli_d    = gecerli_q;
        kirli_d      = kirli_q;
        etiket_yaz   = 1'b0;

        islemci_istek_hazir_o         = 1'b0;
        islemci_cevap_gecerli_o       = 1'b0;
        anabellek_istek_adres_o       = '0;
        anabellek_istek_veri_o        = '0;
        anabellek_istek_gecerli_o     = 1'b0;
        anabellek_istek_yaz_gecerli_o = 1'b0;
        anabellek_cevap_hazir_o       = 1'b0;
        onbellek_istek_gecerli_o      = 1'b0;
        onbellek_istek_yaz_o          = 1'b0;
        onbellek_istek_veri_o         = '0;
        onbellek_istek_adres_o        = '0;

        case (durum_q)
            BOSTA: begin
                // Ready is masked while reset is asserted, since the state
                // register already reads BOSTA then.
                islemci_istek_hazir_o = rst_i;
                if (rst_i && islemci_istek_gecerli_i) begin
                    adres_d                  = islemci_istek_adres_i[31:2];
                    veri_d                   = islemci_istek_veri_i;
                    yaz_d                    = islemci_istek_yaz_i;
                    onbellek_istek_gecerli_o = 1'b1;
                    onbellek_istek_adres_o   = islemci_istek_adres_i[4 +: INDEKS_BIT];
                    durum_d                  = KONTROL;
                end
            end
            KONTROL: begin
                if (isabet) begin
                    if (yaz_q) begin
                        onbellek_istek_gecerli_o = 1'b1;
                        onbellek_istek_yaz_o     = 1'b1;
                        onbellek_istek_veri_o    = bram_birlesik;
                        onbellek_istek_adres_o   = indeks;
                        kirli_d[indeks]          = 1'b1;
                        durum_d                  = BOSTA;
                    end else begin
                        cevap_veri_d = kelime_sec(onbellek_cevap_veri_i, kelime);
                        durum_d      = CEVAP;
                    end
                end else if (gecerli_q[indeks] && kirli_q[indeks]) begin
                    // The BRAM read data is only valid this cycle; keep the victim.
                    kurban_d = onbellek_cevap_veri_i;
                    durum_d  = GERIYAZ;
                end else begin
                    durum_d = GETIR;
                end
            end
            GERIYAZ: begin
                anabellek_istek_gecerli_o     = 1'b1;
                anabellek_istek_yaz_gecerli_o = 1'b1;
                anabellek_istek_adres_o       = {etiket_q[indeks], indeks, 4'b0000};
                anabellek_istek_veri_o        = kurban_q;
                if (anabellek_istek_hazir_i) durum_d = GETIR;
            end
            GETIR: begin
                anabellek_istek_gecerli_o = 1'b1;
                anabellek_istek_adres_o   = {etiket, indeks, 4'b0000};
                if (anabellek_istek_hazir_i) durum_d = BEKLE;
            end
            BEKLE: begin
                anabellek_cevap_hazir_o = 1'b1;
                if (anabellek_cevap_gecerli_i) begin
                    onbellek_istek_gecerli_o = 1'b1;
                    onbellek_istek_yaz_o     = 1'b1;
                    onbellek_istek_veri_o    = getirilen_satir;
                    onbellek_istek_adres_o   = indeks;
                    etiket_yaz               = 1'b1;
                    gecerli_d[indeks]        = 1'b1;
                    kirli_d[indeks]          = yaz_q;
                    if (yaz_q) begin
                        durum_d = BOSTA;
                    end else begin
                        cevap_veri_d = kelime_sec(anabellek_cevap_veri_i, kelime);
                        durum_d      = CEVAP;
                    end
                end
            end
            CEVAP: begin
                islemci_cevap_gecerli_o = 1'b1;
                if (islemci_cevap_hazir_i) durum_d = BOSTA;
            end
            default: durum_d = BOSTA;
        endcase
    end

    // Control state: FSM and per-line valid/dirty bits, cleared by reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            durum_q   <= BOSTA;
            gecerli_q <= '0;
            kirli_q   <= '0;
        end else begin
            durum_q   <= durum_d;
            gecerli_q <= gecerli_d;
            kirli_q   <= kirli_d;
        end
    end

    // Request and line holding registers; their contents only matter once
    // the FSM has loaded them, so they carry no reset.
    always_ff @(posedge clk_i) begin
        adres_q      <= adres_d;
        veri_q       <= veri_d;
        yaz_q        <= yaz_d;
        kurban_q     <= kurban_d;
        cevap_veri_q <= cevap_veri_d;
    end

    // Tag store, written when a fetched line is installed.
    always_ff @(posedge clk_i) begin
        if (etiket_yaz) etiket_q[indeks] <= etiket;
    end

`ifdef ONBELLEK_ISTATISTIK_EN
    logic [31:0] isabet_sayisi_q, iska_sayisi_q;

    // One hit-or-miss count per request, taken in the tag-check cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            isabet_sayisi_q <= '0;
            iska_sayisi_q   <= '0;
        end else if (durum_q == KONTROL) begin
            if (isabet) isabet_sayisi_q <= isabet_sayisi_q + 32'd1;
            else        iska_sayisi_q   <= iska_sayisi_q + 32'd1;
        end
    end

    assign isabet_sayisi_o = isabet_sayisi_q;
    assign iska_sayisi_o   = iska_sayisi_q;
`endif

endmodule

// File: tb/tb_onbellek_denetleyici.sv
// Testbench for onbellek_denetleyici: BRAM and main-memory models, a processor
// driver with a read-data scoreboard, a vector table and corner sequences.
module tb_onbellek_denetleyici;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0]  p_adr = '0;
    logic [31:0]  p_veri = '0;
    logic         p_gec = 1'b0;
    logic         p_yaz = 1'b0;
    logic         cvp_hazir = 1'b1;
    logic         mh = 1'b0;
    logic         mcg = 1'b0;
    logic [127:0] mcv = '0;
    logic [127:0] bram_rd = '0;

    logic         islemci_istek_hazir_o;
    logic [31:0]  islemci_cevap_veri_o;
    logic         islemci_cevap_gecerli_o;
    logic [31:0]  anabellek_istek_adres_o;
    logic [127:0] anabellek_istek_veri_o;
    logic         anabellek_istek_gecerli_o;
    logic         anabellek_istek_yaz_gecerli_o;
    logic         anabellek_cevap_hazir_o;
    logic         onbellek_istek_gecerli_o;
    logic         onbellek_istek_yaz_o;
    logic [127:0] onbellek_istek_veri_o;
    logic [6:0]   onbellek_istek_adres_o;
`ifdef ONBELLEK_ISTATISTIK_EN
    logic [31:0]  isabet_sayisi_o;
    logic [31:0]  iska_sayisi_o;
`endif

    onbellek_denetleyici #(.INDEKS_BIT(7)) dut (
        .clk_i                         (clk),
        .rst_i                         (rst_n),
        .islemci_istek_adres_i         (p_adr),
        .islemci_istek_veri_i          (p_veri),
        .islemci_istek_gecerli_i       (p_gec),
        .islemci_istek_yaz_i           (p_yaz),
        .islemci_istek_hazir_o         (islemci_istek_hazir_o),
        .islemci_cevap_veri_o          (islemci_cevap_veri_o),
        .islemci_cevap_gecerli_o       (islemci_cevap_gecerli_o),
        .islemci_cevap_hazir_i         (cvp_hazir),
        .anabellek_istek_adres_o       (anabellek_istek_adres_o),
        .anabellek_istek_veri_o        (anabellek_istek_veri_o),
        .anabellek_istek_gecerli_o     (anabellek_istek_gecerli_o),
        .anabellek_istek_yaz_gecerli_o (anabellek_istek_yaz_gecerli_o),
        .anabellek_istek_hazir_i       (mh),
        .anabellek_cevap_veri_i        (mcv),
        .anabellek_cevap_gecerli_i     (mcg),
        .anabellek_cevap_hazir_o       (anabellek_cevap_hazir_o),
        .onbellek_istek_gecerli_o      (onbellek_istek_gecerli_o),
        .onbellek_istek_yaz_o          (onbellek_istek_yaz_o),
        .onbellek_istek_veri_o         (onbellek_istek_veri_o),
        .onbellek_istek_adres_o        (onbellek_istek_adres_o),
        .onbellek_cevap_veri_i         (bram_rd)
`ifdef ONBELLEK_ISTATISTIK_EN
        ,
        .isabet_sayisi_o               (isabet_sayisi_o),
        .iska_sayisi_o                 (iska_sayisi_o)
`endif
    );

    // BRAM model: single port, registered read.
    logic [127:0] bram [0:127];
    always @(posedge clk) begin
        if (onbellek_istek_gecerli_o) begin
            if (onbellek_istek_yaz_o) bram[onbellek_istek_adres_o] <= onbellek_istek_veri_o;
            else                      bram_rd <= bram[onbellek_istek_adres_o];
        end
    end

    int gecen = 0;
    int toplam = 0;

    task automatic kontrol(input string ad, input logic [127:0] gercek, input logic [127:0] beklenen);
        toplam++;
        if (gercek === beklenen) gecen++;
        else $display("FAIL %s: actual %0h required %0h", ad, gercek, beklenen);
    endtask

    function automatic logic [31:0] baslangic(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
    endfunction

    // Main memory model: lines for byte addresses 0x0000..0x3FFF.
    typedef struct {
        bit           yaz;
        logic [31:0]  adres;
        logic [127:0] veri;
    } islem_t;

    logic [127:0] ana_mem [0:1023];
    islem_t       log_q[$];
    int           durdur_hedef = 0;
    int           durdur_sayac = 0;

    initial begin
        bit           ist_plan = 0;
        bit           cvp_plan = 0;
        bit           yanit_bekle = 0;
        int           yanit_gecikme = 0;
        logic [127:0] yanit_veri = '0;
        bit           durak_onceki = 0;
        logic [31:0]  durak_adr = '0;
        logic [127:0] durak_veri = '0;
        islem_t       bekleyen;
        bekleyen = '{0, 32'h0, 128'h0};
        for (int i = 0; i < 1024; i++) begin
            logic [31:0] b;
            b = 32'(i) << 4;
            ana_mem[i] = {baslangic(b + 32'd12), baslangic(b + 32'd8), baslangic(b + 32'd4), baslangic(b)};
        end
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mh = 0; mcg = 0; ist_plan = 0; cvp_plan = 0; yanit_bekle = 0; durak_onceki = 0;
                continue;
            end
            if (ist_plan) begin
                log_q.push_back(bekleyen);
                if (bekleyen.yaz) ana_mem[bekleyen.adres[13:4]] = bekleyen.veri;
                else begin
                    yanit_bekle = 1; yanit_gecikme = 2; yanit_veri = ana_mem[bekleyen.adres[13:4]];
                end
                ist_plan = 0;
            end
            if (cvp_plan) begin mcg = 0; cvp_plan = 0; end
            if (anabellek_istek_gecerli_o) begin
                if (durak_onceki) begin
                    kontrol("durak_adres_sabit", anabellek_istek_adres_o, durak_adr);
                    kontrol("durak_veri_sabit", anabellek_istek_veri_o, durak_veri);
                end
                if (durdur_sayac < durdur_hedef) begin
                    durdur_sayac++;
                    mh = 0; durak_onceki = 1;
                    durak_adr = anabellek_istek_adres_o; durak_veri = anabellek_istek_veri_o;
                end else begin
                    mh = 1; durak_onceki = 0; ist_plan = 1;
                    bekleyen = '{anabellek_istek_yaz_gecerli_o, anabellek_istek_adres_o, anabellek_istek_veri_o};
                end
            end else begin
                mh = 0; durak_onceki = 0;
            end
            if (yanit_bekle) begin
                if (yanit_gecikme > 0) yanit_gecikme--;
                else begin mcg = 1; mcv = yanit_veri; yanit_bekle = 0; end
            end
            if (mcg && anabellek_cevap_hazir_o) cvp_plan = 1;
        end
    end

    // Response monitor: scoreboard pops and the response-hold corner case.
    logic [31:0] sb_q[$];
    int          tut_hedef = 0;
    int          tut_sayac = 0;

    initial begin
        bit          tutuluyor = 0;
        logic [31:0] tut_veri = '0;
        logic [31:0] bek;
        forever begin
            @(negedge clk);
            if (!rst_n) begin cvp_hazir = 1; tutuluyor = 0; continue; end
            if (islemci_cevap_gecerli_o) begin
                if (tut_sayac < tut_hedef) begin
                    if (!tutuluyor) begin tutuluyor = 1; tut_veri = islemci_cevap_veri_o; end
                    else kontrol("tut_veri_sabit", islemci_cevap_veri_o, tut_veri);
                    kontrol("tut_kabul_yok", islemci_istek_hazir_o, 1'b0);
                    tut_sayac++;
                    cvp_hazir = 0;
                end else begin
                    if (tutuluyor) kontrol("tut_veri_sabit", islemci_cevap_veri_o, tut_veri);
                    tutuluyor = 0;
                    cvp_hazir = 1;
                    if (sb_q.size() == 0) kontrol("sb_bos", 1'b1, 1'b0);
                    else begin
                        bek = sb_q.pop_front();
                        kontrol("okuma_verisi", islemci_cevap_veri_o, bek);
                    end
                end
            end
        end
    end

    logic [31:0] ref_mem [int];

    function automatic logic [31:0] ref_oku(input logic [31:0] a);
        if (ref_mem.exists(int'(a >> 2))) return ref_mem[int'(a >> 2)];
        return baslangic(a);
    endfunction

    task automatic istek(input bit yaz, input logic [31:0] a, input logic [31:0] d, input logic [31:0] bek);
        int n;
        @(negedge clk);
        p_gec = 1; p_yaz = yaz; p_adr = a; p_veri = d;
        n = 0;
        while (!islemci_istek_hazir_o && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) begin
            kontrol("kabul_zaman_asimi", 1'b0, 1'b1);
            p_gec = 0;
            return;
        end
        if (yaz) ref_mem[int'(a >> 2)] = d;
        else     sb_q.push_back(bek);
        @(posedge clk);
        @(negedge clk);
        p_gec = 0;
    endtask

    task automatic bekle_bos();
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (islemci_istek_hazir_o && sb_q.size() == 0) return;
        end
        kontrol("bosta_zaman_asimi", 1'b0, 1'b1);
    endtask

    task automatic log_kontrol(input string ad, input int idx, input bit yaz, input logic [31:0] adres);
        if (idx >= log_q.size()) kontrol({ad, "_yok"}, 1'b0, 1'b1);
        else begin
            kontrol({ad, "_yaz"}, log_q[idx].yaz, yaz);
            kontrol({ad, "_adres"}, log_q[idx].adres, adres);
        end
    endtask

    task automatic log_kelime(input string ad, input int idx, input int w, input logic [31:0] bek);
        if (idx >= log_q.size()) kontrol({ad, "_yok"}, 1'b0, 1'b1);
        else kontrol(ad, log_q[idx].veri[w*32 +: 32], bek);
    endtask

    typedef struct {
        bit          yaz;
        logic [31:0] adres;
        logic [31:0] veri;
        logic [31:0] beklenen;
        int          trafik;
    } vektor_t;

    initial begin
        vektor_t tablo[13];
        int      bas[13];
        int      b;

        tablo[0]  = '{0, 32'h0000, 32'h0,         baslangic(32'h0),     1};
        tablo[1]  = '{0, 32'h0008, 32'h0,         baslangic(32'h8),     0};
        tablo[2]  = '{1, 32'h0004, 32'hABCD_0000, 32'h0,                0};
        tablo[3]  = '{0, 32'h0004, 32'h0,         32'hABCD_0000,        0};
        tablo[4]  = '{1, 32'h0000, 32'hCAFE_0001, 32'h0,                0};
        tablo[5]  = '{0, 32'h0800, 32'h0,         baslangic(32'h800),   2};
        tablo[6]  = '{1, 32'h0804, 32'h1111_2222, 32'h0,                0};
        tablo[7]  = '{0, 32'h0000, 32'h0,         32'hCAFE_0001,        2};
        tablo[8]  = '{0, 32'h0804, 32'h0,         32'h1111_2222,        1};
        tablo[9]  = '{0, 32'h0010, 32'h0,         baslangic(32'h10),    1};
        tablo[10] = '{1, 32'h0020, 32'h0000_0055, 32'h0,                1};
        tablo[11] = '{0, 32'h0024, 32'h0,         baslangic(32'h24),    0};
        tablo[12] = '{0, 32'h0020, 32'h0,         32'h0000_0055,        0};

        // Reset state.
        repeat (3) @(negedge clk);
        kontrol("rst_istek_hazir", islemci_istek_hazir_o, 1'b0);
        kontrol("rst_cevap_gecerli", islemci_cevap_gecerli_o, 1'b0);
        kontrol("rst_anabellek_gecerli", anabellek_istek_gecerli_o, 1'b0);
        kontrol("rst_anabellek_cevap_hazir", anabellek_cevap_hazir_o, 1'b0);
        kontrol("rst_bram_gecerli", onbellek_istek_gecerli_o, 1'b0);
        rst_n = 1;
        @(negedge clk);
        kontrol("bosta_hazir", islemci_istek_hazir_o, 1'b1);

        // Vector table.
        for (int i = 0; i < 13; i++) begin
            bas[i] = log_q.size();
            istek(tablo[i].yaz, tablo[i].adres, tablo[i].veri, tablo[i].beklenen);
            bekle_bos();
            kontrol($sformatf("trafik_%0d", i), 128'(log_q.size() - bas[i]), 128'(tablo[i].trafik));
        end
        log_kontrol("ilk_iska_okuma", bas[0], 0, 32'h0000_0000);
        log_kontrol("geriyaz_0", bas[5], 1, 32'h0000_0000);
        log_kelime("geriyaz_0_kelime0", bas[5], 0, 32'hCAFE_0001);
        log_kelime("geriyaz_0_kelime1", bas[5], 1, 32'hABCD_0000);
        log_kontrol("getir_800", bas[5] + 1, 0, 32'h0000_0800);

        // Write-back stalled by memory for 10 cycles.
        b = log_q.size();
        istek(1, 32'h0040, 32'h0000_0077, 32'h0);
        bekle_bos();
        durdur_hedef = durdur_sayac + 10;
        istek(0, 32'h0840, 32'h0, baslangic(32'h840));
        bekle_bos();
        kontrol("durak_sayisi", 128'(durdur_sayac), 128'(durdur_hedef));
        log_kontrol("durak_geriyaz", b + 1, 1, 32'h0000_0040);
        log_kelime("durak_geriyaz_kelime0", b + 1, 0, 32'h0000_0077);
        log_kontrol("durak_getir", b + 2, 0, 32'h0000_0840);

        // Read hit: one-cycle latency, then response held for 5 cycles.
        tut_hedef = tut_sayac + 5;
        b = log_q.size();
        istek(0, 32'h0024, 32'h0, baslangic(32'h24));
        kontrol("gecikme_kabul_sonrasi", islemci_cevap_gecerli_o, 1'b0);
        @(negedge clk);
        kontrol("gecikme_cevap", islemci_cevap_gecerli_o, 1'b1);
        istek(0, 32'h0020, 32'h0, 32'h0000_0055);
        bekle_bos();
        kontrol("tut_sayisi", 128'(tut_sayac), 128'(tut_hedef));
        kontrol("isabet_trafik_yok", 128'(log_q.size() - b), 128'(0));

        // Reset in the middle of a miss abandons it and clears valid bits.
        istek(0, 32'h2000, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 0;
        sb_q.delete();
        @(negedge clk);
        kontrol("ara_rst_istek_hazir", islemci_istek_hazir_o, 1'b0);
        kontrol("ara_rst_anabellek_gecerli", anabellek_istek_gecerli_o, 1'b0);
        kontrol("ara_rst_anabellek_cevap_hazir", anabellek_cevap_hazir_o, 1'b0);
        kontrol("ara_rst_cevap_gecerli", islemci_cevap_gecerli_o, 1'b0);
        @(negedge clk);
        rst_n = 1;
        b = log_q.size();
        istek(0, 32'h0024, 32'h0, baslangic(32'h24));
        bekle_bos();
        kontrol("rst_sonrasi_iska", 128'(log_q.size() - b), 128'(1));

        // Capacity sweep: write then read back 4096 words.
        for (int a = 0; a < 32'h4000; a += 4) begin
            logic [31:0] aa;
            aa = 32'(a);
            istek(1, aa, (32'hABCD_0000 + aa) & 32'hFFFF_FFFC, 32'h0);
        end
        for (int a = 0; a < 32'h4000; a += 4) begin
            logic [31:0] aa;
            aa = 32'(a);
            istek(0, aa, 32'h0, ref_oku(aa));
        end
        bekle_bos();
        kontrol("sb_sonunda_bos", 128'(sb_q.size()), 128'(0));

        $display("%0d/%0d checks passed", gecen, toplam);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required completion");
        $display("%0d/%0d checks passed", gecen, toplam + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/onbellek_denetleyici.md
Name: onbellek_denetleyici

Overview:
- Direct-mapped, write-back, write-allocate data cache controller between a 32-bit processor port and a 128-bit-line main-memory port.
- Line data lives in an external single-port BRAM (128 x 128 bit, 1-cycle registered read); tags and valid/dirty bits live in controller registers.
- Processor writes return no response; reads return one 32-bit word.

Parameters:
- INDEKS_BIT, 7, index width; line count = 2^INDEKS_BIT; must match BRAM depth.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- islemci_istek_adres_i  in  32  byte address; [1:0] ignored, [3:2] word offset, [10:4] index, [31:11] tag.
- islemci_istek_veri_i  in  32  write data.
- islemci_istek_gecerli_i  in  1  request valid.
- islemci_istek_yaz_i  in  1  1 = write, 0 = read.
- islemci_istek_hazir_o  out  1  request ready.
- islemci_cevap_veri_o  out  32  read data.
- islemci_cevap_gecerli_o  out  1  response valid.
- islemci_cevap_hazir_i  in  1  response ready.
- anabellek_istek_adres_o  out  32  line address, {tag, index, 4'b0}.
- anabellek_istek_veri_o  out  128  write-back line.
- anabellek_istek_gecerli_o  out  1  memory request valid.
- anabellek_istek_yaz_gecerli_o  out  1  1 = line write, 0 = line read.
- anabellek_istek_hazir_i  in  1  memory request ready.
- anabellek_cevap_veri_i  in  128  fetched line.
- anabellek_cevap_gecerli_i  in  1  fetched line valid.
- anabellek_cevap_hazir_o  out  1  controller ready for the line.
- onbellek_istek_gecerli_o  out  1  BRAM command enable.
- onbellek_istek_yaz_o  out  1  BRAM write enable.
- onbellek_istek_veri_o  out  128  BRAM write data.
- onbellek_istek_adres_o  out  INDEKS_BIT  BRAM line index.
- onbellek_cevap_veri_i  in  128  BRAM read data, valid the cycle after a read command.

Behaviour:
- Reset (rst_i = 0, async):
  - State returns to BOSTA; all valid/dirty bits are cleared; tags are don't-care.
  - Every valid/enable output is 0 and islemci_istek_hazir_o = 0.
  - A reset mid-transaction abandons that transaction; BRAM contents are not cleared.
- Word w = addr[3:2] maps to line bits [32w+31:32w].
- State BOSTA: islemci_istek_hazir_o = 1.
  - On gecerli & hazir: latch address, data and write flag.
  - In the same cycle drive a BRAM read (cmd_en = 1, wr_en = 0, adres = index), then go to KONTROL.
- State KONTROL: the BRAM line is available; hit = valid[index] & tag match.
  - Read hit: load the word into islemci_cevap_veri_o, go to CEVAP. Latency: response valid from the first edge after acceptance.
  - Write hit: BRAM write of the line with the word merged; set dirty; go to BOSTA, ready again one cycle after acceptance.
  - Miss with the victim valid & dirty: go to GERIYAZ, holding the BRAM line in a register.
  - Any other miss: go to GETIR.
- State GERIYAZ: assert gecerli = 1, yaz = 1, adres = {old tag, index, 0}, veri = victim line.
  - On anabellek_istek_hazir_i, go to GETIR. A memory write produces no response.
- State GETIR: assert gecerli = 1, yaz = 0, adres = {new tag, index, 0}; on hazir, go to BEKLE.
- State BEKLE: anabellek_cevap_hazir_o = 1. On anabellek_cevap_gecerli_i:
  - Write the line to BRAM, with the processor word merged if the request was a write.
  - Set tag and valid; dirty = write flag.
  - Read: respond with the word taken from the fetched line and go to CEVAP. Write: go to BOSTA.
- State CEVAP: islemci_cevap_gecerli_o = 1 with stable data until islemci_cevap_hazir_i, then go to BOSTA.
- Memory request outputs hold stable while gecerli = 1 and hazir = 0.
- BRAM outputs are 0 whenever unused.
- Only one outstanding processor request; islemci_istek_hazir_o = 0 outside BOSTA.

Optional Feature:
- Macro ONBELLEK_ISTATISTIK_EN adds outputs isabet_sayisi_o[31:0] and iska_sayisi_o[31:0].
  - Each counter increments once per request in KONTROL (hit or miss respectively).
  - Counters clear on reset and wrap at 2^32.
- Without the macro, these ports and their logic do not exist.

Test Plan:
- Reset, then read addr 0x0 -> miss, memory read request at 0x00000000, response equals word 0 of the returned line, valid bit set.
- Write 0xABCD0000 to addr 0x4, then read addr 0x4 -> hit, 0xABCD0000 returned one cycle after acceptance, no memory traffic.
- Write addr 0x0 (dirty), then read addr 0x800 (same index, different tag):
  - memory write of the line at 0x00000000 whose word 0 is the written data;
  - then a read at 0x00000800.
- Write words 0x0..0x3FFC with value (0xABCD0000 + a) & 0xFFFFFFFC, then read back all -> every read matches; capacity evictions are exercised.
- Hold islemci_cevap_hazir_i = 0 for 5 cycles on a read -> gecerli and data stay stable, no new request is accepted.
- Stall anabellek_istek_hazir_i for 10 cycles during GERIYAZ -> address and data stay stable, completion is correct.
